alarm_ring: RTL
===============

# alarm_ring

Alarm stage of the digital clock, directly downstream of the mode selector. Captures the alarm time from the keyboard while the selector is in alarm-set mode, compares it each second against the running time, and drives a gated square-wave buzzer for a bounded ring period. It also holds the stored alarm time for display in alarm-view mode.

## Interface
Parameters:
- TONE_DIV, 25000, half-period of the buzzer tone in clk cycles (1 kHz at 50 MHz); ≥2.
- RING_SEC, 60, ring duration in sec_tick pulses; 2..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ring_load  in  1  level from mode selector: alarm-set mode active.
- keyboard_load  in  1  one-cycle pulse from mode selector: commit keyboard value.
- key_data  in  16  BCD {hour_t, hour_u, min_t, min_u} from keyboard.
- cur_hour  in  8  current time, BCD hours.
- cur_min  in  8  current time, BCD minutes.
- cur_sec  in  8  current time, BCD seconds.
- sec_tick  in  1  one-cycle pulse, once per second; cur_* are valid in that cycle.
- stop  in  1  one-cycle filtered key pulse: silence the alarm.
- alarm_hour  out  8  stored alarm hour, BCD.
- alarm_min  out  8  stored alarm minute, BCD.
- alarm_valid  out  1  an alarm time has been loaded since reset.
- load_err  out  1  one-cycle pulse: rejected load.
- ringing  out  1  alarm is ringing.
- buzzer  out  1  buzzer drive.

## Operation
- Load: when ring_load && keyboard_load, validate key_data. Valid = every nibble ≤9, hour ≤ 0x23, min ≤ 0x59. If valid, update alarm_hour/alarm_min and set alarm_valid. If invalid, keep old values and pulse load_err. keyboard_load without ring_load is ignored.
- FSM states: IDLE, RING.
- IDLE→RING: sec_tick && alarm_valid && !stop && cur_hour==alarm_hour && cur_min==alarm_min && cur_sec==0x00. Clear ring_cnt.
- RING: ring_cnt increments on each sec_tick.
- RING→IDLE: stop pulse, or sec_tick with ring_cnt==RING_SEC-1.
- Tone: in RING with ring_cnt[0]==0 (1 s on / 1 s off), tone counter runs 0..TONE_DIV-1 and buzzer toggles at the wrap. Otherwise the tone counter is held at 0 and buzzer is 0.
- Simultaneous events:
  - A trigger and stop in the same cycle: stop wins; stay IDLE.
  - A load during RING updates the alarm; ringing continues.
  - A load in the trigger cycle: compare against the old alarm value.
- No retrigger in the same minute, since the trigger requires cur_sec==00.
- A reset mid-ring forces IDLE immediately.

## Timing
- Reset values: alarm_hour=0x00, alarm_min=0x00, alarm_valid=0, load_err=0, ringing=0, buzzer=0, ring_cnt=0, tone counter=0, state IDLE.
- All outputs are registered.
- alarm_* and alarm_valid update 1 cycle after the keyboard_load cycle. load_err is high exactly 1 cycle, 1 cycle after keyboard_load.
- ringing rises 1 cycle after the trigger cycle and falls 1 cycle after the stop or final sec_tick. It spans exactly RING_SEC sec_ticks when not stopped.
- First buzzer rise occurs TONE_DIV cycles after ringing rises. Buzzer goes to 0 within 1 cycle of the gate closing or of leaving RING.

## Test plan
1. Reset values: after reset, all outputs 0. Then load key_data=0x0730 with ring_load=1 and a keyboard_load pulse → alarm_hour=0x07, alarm_min=0x30, alarm_valid=1, no load_err.
2. Invalid loads: key_data=0x2460, then 0x1A00 → load_err pulses twice; alarm stays 07:30.
3. Trigger and full ring (TONE_DIV=4, RING_SEC=4): cur=07:30:00 with sec_tick → ringing next cycle. Buzzer toggles every 4 cycles during ring seconds 0 and 2 and is 0 during seconds 1 and 3. ringing drops after the 4th sec_tick.
4. Stop handling: stop pulse during ring second 1 → ringing=0 and buzzer=0 next cycle. A trigger with stop in the same cycle → no ring.
5. Near-misses: cur=07:30:01 with tick, 07:31:00 with tick, and 07:30:00 without tick → no ring. With alarm_valid=0 and cur=00:00:00 with tick → no ring.
6. Reset mid-ring: assert rst_n=0 while ringing → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alarm_ring.sv
// Alarm stage: validates and stores the alarm time, detects the alarm minute
// and drives a gated square-wave buzzer for a bounded ring period.
module alarm_ring #(
    parameter int TONE_DIV = 25000,
    parameter int RING_SEC = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ring_load,
    input  logic        keyboard_load,
    input  logic [15:0] key_data,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_sec,
    input  logic        sec_tick,
    input  logic        stop,
    output logic [7:0]  alarm_hour,
    output logic [7:0]  alarm_min,
    output logic        alarm_valid,
    output logic        load_err,
    output logic        ringing,
    output logic        buzzer
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic {IDLE, RING} state_t;

    state_t        state, next_state;
    logic [7:0]    ring_cnt, ring_cnt_next;
    logic [TW-1:0] tone_cnt;
    logic          load_cmd, key_ok, trigger, final_tick;
    logic          gate_now, gate_next, tone_run;

    assign load_cmd = ring_load && keyboard_load;

    assign key_ok = (key_data[15:12] <= 4'd9) && (key_data[11:8] <= 4'd9) &&
                    (key_data[7:4]   <= 4'd9) && (key_data[3:0]  <= 4'd9) &&
                    (key_data[15:8]  <= 8'h23) && (key_data[7:0] <= 8'h59);

    // Compares against the registered alarm, so a same-cycle load sees the old value.
    assign trigger = sec_tick && alarm_valid && !stop &&
                     (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                     (cur_sec == 8'h00);

    assign final_tick = sec_tick && (ring_cnt == 8'(RING_SEC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            ring_cnt <= ring_cnt_next;
        end
    end

    always_comb begin
        next_state    = state;
        ring_cnt_next = ring_cnt;
        case (state)
            IDLE: begin
                ring_cnt_next = 8'd0;
                if (trigger)
                    next_state = RING;
            end
            RING: begin
                if (sec_tick)
                    ring_cnt_next = ring_cnt + 8'd1;
                if (stop || final_tick) begin
                    next_state    = IDLE;
                    ring_cnt_next = 8'd0;
                end
            end
            default: begin
                next_state    = IDLE;
                ring_cnt_next = 8'd0;
            end
        endcase
    end

    // The tone only advances while the gate stays open across the edge, so every
    // on-second starts from a fresh tone phase and silences on the closing edge.
    always_comb begin
        gate_now  = (state == RING) && !ring_cnt[0];
        gate_next = (next_state == RING) && !ring_cnt_next[0];
        tone_run  = gate_now && gate_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
            ringing  <= 1'b0;
        end else begin
            ringing <= (next_state == RING);
            if (tone_run) begin
                if (tone_cnt == TW'(TONE_DIV - 1)) begin
                    tone_cnt <= '0;
                    buzzer   <= ~buzzer;
                end else begin
                    tone_cnt <= tone_cnt + 1'b1;
                end
            end else begin
                tone_cnt <= '0;
                buzzer   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour  <= 8'h00;
            alarm_min   <= 8'h00;
            alarm_valid <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_err <= load_cmd && !key_ok;
            if (load_cmd && key_ok) begin
                alarm_hour  <= key_data[15:8];
                alarm_min   <= key_data[7:0];
                alarm_valid <= 1'b1;
            end
        end
    end

endmodule
